pipeline_debug_tx: RTL and testbench

PIPELINE_DEBUG_TX -- requirements
Module: pipeline_debug_tx

---
 rtl/pipeline_debug_tx.sv | 170 +++++++++++++++++
 tb/tb_pipeline_debug_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_tx.sv
// Serialises a snapshot of pipeline stage registers into a 27-byte framed byte stream
// (header, six 32-bit words MSB first, WB status, XOR checksum) over a valid/ready link.
module pipeline_debug_tx #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        capture,
    input  logic [31:0] PC_sumado_IF,
    input  logic [31:0] instruction_IF,
    input  logic [31:0] instruction_ID,
    input  logic [31:0] ALU_result_EX,
    input  logic [31:0] ALU_result_MEM,
    input  logic [31:0] Read_data_WB,
    input  logic [4:0]  Write_register_WB,
    input  logic        RegWrite_WB,
    input  logic        MemToReg_WB,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  frame_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [4:0] LAST_IDX   = 5'd26;
    localparam logic [4:0] STATUS_IDX = 5'd25;
    localparam logic [4:0] WORDS_LAST = 5'd24;

    logic [0:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  chk_q, chk_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  fcount_q, fcount_d;
    logic        load_snap;

    logic [31:0] pc_q, ins_if_q, ins_id_q, alu_ex_q, alu_mem_q, rd_wb_q;
    logic [4:0]  wreg_q;
    logic        regwr_q, memtoreg_q;

    logic [31:0] snap_words [6];
    logic [7:0]  snap_bytes [24];
    logic [4:0]  next_idx;
    logic [4:0]  byte_sel;
    logic [7:0]  next_byte;

    // Snapshot only moves on an accepted capture, so the frame is immune to later input changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= '0;
            ins_if_q   <= '0;
            ins_id_q   <= '0;
            alu_ex_q   <= '0;
            alu_mem_q  <= '0;
            rd_wb_q    <= '0;
            wreg_q     <= '0;
            regwr_q    <= 1'b0;
            memtoreg_q <= 1'b0;
        end else if (load_snap) begin
            pc_q       <= PC_sumado_IF;
            ins_if_q   <= instruction_IF;
            ins_id_q   <= instruction_ID;
            alu_ex_q   <= ALU_result_EX;
            alu_mem_q  <= ALU_result_MEM;
            rd_wb_q    <= Read_data_WB;
            wreg_q     <= Write_register_WB;
            regwr_q    <= RegWrite_WB;
            memtoreg_q <= MemToReg_WB;
        end
    end

    always_comb begin
        snap_words[0] = pc_q;
        snap_words[1] = ins_if_q;
        snap_words[2] = ins_id_q;
        snap_words[3] = alu_ex_q;
        snap_words[4] = alu_mem_q;
        snap_words[5] = rd_wb_q;
        for (int w = 0; w < 6; w++) begin
            for (int b = 0; b < 4; b++) begin
                snap_bytes[4*w+b] = snap_words[w][31-8*b -: 8];
            end
        end
    end

    assign next_idx = idx_q + 5'd1;
    assign byte_sel = idx_q;

    // tx_data is registered, so the byte after the current one is selected here.
    // chk_q holds the XOR of all bytes already sent; folding in data_q yields the checksum.
    always_comb begin
        next_byte = 8'h00;
        if (next_idx <= WORDS_LAST) begin
            next_byte = snap_bytes[byte_sel];
        end else if (next_idx == STATUS_IDX) begin
            next_byte = {regwr_q, memtoreg_q, 1'b0, wreg_q};
        end else if (next_idx == LAST_IDX) begin
            next_byte = chk_q ^ data_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        chk_d     = chk_q;
        overrun_d = overrun_q;
        fcount_d  = fcount_q;
        load_snap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    load_snap = 1'b1;
                    idx_d     = 5'd0;
                    data_d    = HEADER;
                    chk_d     = 8'h00;
                    overrun_d = 1'b0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (capture) begin
                    overrun_d = 1'b1;
                end
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = ST_IDLE;
                        idx_d    = 5'd0;
                        data_d   = 8'h00;
                        fcount_d = fcount_q + 8'd1;
                    end else begin
                        idx_d  = next_idx;
                        data_d = next_byte;
                        chk_d  = chk_q ^ data_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 5'd0;
            data_q    <= 8'h00;
            chk_q     <= 8'h00;
            overrun_q <= 1'b0;
            fcount_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            chk_q     <= chk_d;
            overrun_q <= overrun_d;
            fcount_q  <= fcount_d;
        end
    end

    assign tx_valid    = (state_q == ST_SEND);
    assign busy        = (state_q == ST_SEND);
    assign tx_data     = data_q;
    assign overrun     = overrun_q;
    assign frame_count = fcount_q;

endmodule

// File: tb/tb_pipeline_debug_tx.sv
// Self-checking bench for pipeline_debug_tx: table-driven frames plus hand sequences,
// with a byte scoreboard fed by a reference frame builder.
module tb_pipeline_debug_tx;

    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        capture = 1'b0;
    logic [31:0] PC_sumado_IF = '0;
    logic [31:0] instruction_IF = '0;
    logic [31:0] instruction_ID = '0;
    logic [31:0] ALU_result_EX = '0;
    logic [31:0] ALU_result_MEM = '0;
    logic [31:0] Read_data_WB = '0;
    logic [4:0]  Write_register_WB = '0;
    logic        RegWrite_WB = 1'b0;
    logic        MemToReg_WB = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        overrun;
    logic [7:0]  frame_count;

    always #5 clk = ~clk;

    pipeline_debug_tx #(.HEADER(HDR)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .capture           (capture),
        .PC_sumado_IF      (PC_sumado_IF),
        .instruction_IF    (instruction_IF),
        .instruction_ID    (instruction_ID),
        .ALU_result_EX     (ALU_result_EX),
        .ALU_result_MEM    (ALU_result_MEM),
        .Read_data_WB      (Read_data_WB),
        .Write_register_WB (Write_register_WB),
        .RegWrite_WB       (RegWrite_WB),
        .MemToReg_WB       (MemToReg_WB),
        .tx_ready          (tx_ready),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .busy              (busy),
        .overrun           (overrun),
        .frame_count       (frame_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins_if;
        logic [31:0] ins_id;
        logic [31:0] alu_ex;
        logic [31:0] alu_mem;
        logic [31:0] rd_wb;
        logic [4:0]  wreg;
        logic        regwr;
        logic        memtoreg;
        int          mode;      // 0: always ready, 1: 1,0,0,1 pattern, 2: random
        bit          scramble;  // change data inputs every cycle during SEND
        bit          has_chk;
        logic [7:0]  chk;
    } vec_t;

    vec_t        tbl [5];
    logic [7:0]  exp_q [$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  last_tx = 8'h00;
    logic [7:0]  exp_fc = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_inputs(input vec_t v);
        PC_sumado_IF      = v.pc;
        instruction_IF    = v.ins_if;
        instruction_ID    = v.ins_id;
        ALU_result_EX     = v.alu_ex;
        ALU_result_MEM    = v.alu_mem;
        Read_data_WB      = v.rd_wb;
        Write_register_WB = v.wreg;
        RegWrite_WB       = v.regwr;
        MemToReg_WB       = v.memtoreg;
    endtask

    task automatic push_frame(input vec_t v);
        logic [7:0]  b [27];
        logic [31:0] w [6];
        logic [7:0]  x;
        w = '{v.pc, v.ins_if, v.ins_id, v.alu_ex, v.alu_mem, v.rd_wb};
        b[0] = HDR;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 4; j++)
                b[1+4*i+j] = 8'(w[i] >> (24 - 8*j));
        b[25] = {v.regwr, v.memtoreg, 1'b0, v.wreg};
        x = 8'h00;
        for (int i = 0; i < 26; i++) x = x ^ b[i];
        b[26] = x;
        for (int i = 0; i < 27; i++) exp_q.push_back(b[i]);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.pc = $urandom; v.ins_if = $urandom; v.ins_id = $urandom;
        v.alu_ex = $urandom; v.alu_mem = $urandom; v.rd_wb = $urandom;
        v.wreg = 5'($urandom); v.regwr = 1'($urandom); v.memtoreg = 1'($urandom);
        v.mode = 0; v.scramble = 1'b0; v.has_chk = 1'b0; v.chk = 8'h00;
        return v;
    endfunction

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return ((c % 4) == 0) || ((c % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Called at posedge+1 in IDLE; returns at posedge+1 after the capture edge.
    task automatic start_frame(input vec_t v);
        drive_inputs(v);
        capture = 1'b1;
        push_frame(v);
        @(posedge clk); #1;
        capture = 1'b0;
        check("busy_after_capture", 32'(busy), 32'd1);
        check("header_valid", 32'(tx_valid), 32'd1);
    endtask

    // Runs the current frame to completion; optional capture pulses on the edges
    // transferring bytes cap_a / cap_b.
    task automatic run_to_idle(input int mode, input bit scramble, input int cap_a, input int cap_b);
        int  c = 0;
        int  sent = 0;
        logic xfer;
        while (busy && c < 300) begin
            tx_ready = ready_for(mode, c);
            if (scramble) drive_inputs(rand_vec());
            xfer = tx_valid && tx_ready;
            capture = xfer && (sent == cap_a || sent == cap_b);
            @(posedge clk); #1;
            if (xfer) sent++;
            c++;
        end
        capture = 1'b0;
        check("frame_done", 32'(busy), 32'd0);
        check("handshakes", 32'(sent), 32'd27);
    endtask

    task automatic post_frame_checks(input logic exp_ov);
        check("frame_count", 32'(frame_count), 32'(exp_fc));
        check("overrun", 32'(overrun), 32'(exp_ov));
        check("idle_valid", 32'(tx_valid), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: a byte seen valid&ready at negedge transfers on the next posedge.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(tx_valid), 32'd1);
                    check("stall_hold", 32'(tx_data), 32'(prev_data));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", 32'(tx_data), 32'(e));
                        last_tx = tx_data;
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    initial begin
        tbl[0] = '{32'h00000004, 32'h8C010000, 32'h00221820, 32'h0000000A, 32'h00000005,
                   32'hDEADBEEF, 5'd3, 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'hD8};
        tbl[1] = '{32'h00000004, 32'h8C010000, 32'h00221820, 32'h0000000A, 32'h00000005,
                   32'hDEADBEEF, 5'd3, 1'b1, 1'b1, 1, 1'b0, 1'b1, 8'hD8};
        tbl[2] = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978, 32'h87968574,
                   32'hC3D2E1F0, 5'd17, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
                   32'h55AA55AA, 5'd9, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h00};
        tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFF, 5'd31, 1'b0, 1'b1, 1, 1'b1, 1'b0, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_fcount", 32'(frame_count), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_capture", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            start_frame(tbl[i]);
            run_to_idle(tbl[i].mode, tbl[i].scramble, -1, -1);
            exp_fc = exp_fc + 8'd1;
            post_frame_checks(1'b0);
            if (tbl[i].has_chk) check("checksum", 32'(last_tx), 32'(tbl[i].chk));
        end

        // Captures during SEND (mid-frame and on the final byte edge) are dropped.
        start_frame(tbl[2]);
        run_to_idle(0, 1'b0, 10, 26);
        exp_fc = exp_fc + 8'd1;
        post_frame_checks(1'b1);
        start_frame(tbl[3]);
        check("overrun_cleared", 32'(overrun), 32'd0);
        run_to_idle(0, 1'b0, -1, -1);
        exp_fc = exp_fc + 8'd1;
        post_frame_checks(1'b0);

        // Reset while byte 12 is presented aborts the frame.
        start_frame(tbl[0]);
        tx_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        exp_fc = 8'h00;
        #1;
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", 32'(tx_data), 32'd0);
        check("abort_fcount", 32'(frame_count), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_reset_quiet", 32'(tx_valid), 32'd0);
        end

        // Back-to-back frames with a single IDLE cycle between them; counter wraps.
        for (int i = 0; i < 256; i++) begin
            start_frame(rand_vec());
            run_to_idle(0, 1'b0, -1, -1);
            exp_fc = exp_fc + 8'd1;
            check("wrap_fcount", 32'(frame_count), 32'(exp_fc));
            check("wrap_overrun", 32'(overrun), 32'd0);
        end
        check("wrap_final", 32'(frame_count), 32'd0);
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
